// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: sine and cosine of a signed Q2.16 angle.
// One micro-rotation per clock; the angle is folded into [-pi/2, pi/2] at
// load and the result is negated back at the end when the fold was taken.
module cordic_sincos #(
  parameter int ITERATIONS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [17:0] angle_in,
  output logic        busy,
  output logic        done,
  output logic [17:0] cos_out,
  output logic [17:0] sin_out
);

  localparam logic signed [19:0] PI_Q      = 20'sd205887;
  localparam logic signed [19:0] HALF_PI_Q = 20'sd102944;
  localparam logic signed [19:0] K_INIT    = 20'sd39797;
  localparam logic [3:0]         LAST_ITER = 4'(ITERATIONS - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ROTATE = 1'b1
  } state_t;

  // arctangent table, atan(2^-i) in Q2.16
  function automatic logic signed [19:0] atan_rom(input logic [3:0] idx);
    logic signed [19:0] v;
    case (idx)
      4'd0:    v = 20'sd51472;
      4'd1:    v = 20'sd30386;
      4'd2:    v = 20'sd16055;
      4'd3:    v = 20'sd8150;
      4'd4:    v = 20'sd4091;
      4'd5:    v = 20'sd2047;
      4'd6:    v = 20'sd1024;
      4'd7:    v = 20'sd512;
      4'd8:    v = 20'sd256;
      4'd9:    v = 20'sd128;
      4'd10:   v = 20'sd64;
      4'd11:   v = 20'sd32;
      4'd12:   v = 20'sd16;
      4'd13:   v = 20'sd8;
      4'd14:   v = 20'sd4;
      4'd15:   v = 20'sd2;
      default: v = 20'sd0;
    endcase
    return v;
  endfunction

  // clamp a 20-bit internal value into the 18-bit output range
  function automatic logic [17:0] sat18(input logic signed [19:0] v);
    logic [17:0] r;
    if (v > 20'sd131071) begin
      r = 18'h1FFFF;
    end else if (v < -20'sd131072) begin
      r = 18'h20000;
    end else begin
      r = v[17:0];
    end
    return r;
  endfunction

  state_t             state_r, state_s;
  logic signed [19:0] x_r, y_r, z_r;
  logic [3:0]         cnt_r;
  logic               neg_r;

  logic signed [19:0] angle_ext_s, z0_s;
  logic               neg0_s;
  logic signed [19:0] x_sh_s, y_sh_s, atan_s;
  logic signed [19:0] x_nx_s, y_nx_s, z_nx_s;
  logic signed [19:0] x_fin_s, y_fin_s;
  logic               last_s;

  assign last_s = (cnt_r == LAST_ITER);

  // next-state logic: IDLE waits for start, ROTATE runs until the last iteration
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = ROTATE;
        end else begin
          state_s = IDLE;
        end
      end
      ROTATE: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = ROTATE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // quadrant fold of the incoming angle into the CORDIC convergence range
  always_comb begin
    angle_ext_s = {{2{angle_in[17]}}, angle_in};
    z0_s        = angle_ext_s;
    neg0_s      = 1'b0;
    if (angle_ext_s > HALF_PI_Q) begin
      z0_s   = angle_ext_s - PI_Q;
      neg0_s = 1'b1;
    end else if (angle_ext_s < -HALF_PI_Q) begin
      z0_s   = angle_ext_s + PI_Q;
      neg0_s = 1'b1;
    end else begin
      z0_s   = angle_ext_s;
      neg0_s = 1'b0;
    end
  end

  // one micro-rotation, direction chosen by the sign of the residual angle
  always_comb begin
    x_sh_s = x_r >>> cnt_r;
    y_sh_s = y_r >>> cnt_r;
    atan_s = atan_rom(cnt_r);
    x_nx_s = x_r;
    y_nx_s = y_r;
    z_nx_s = z_r;
    if (!z_r[19]) begin
      x_nx_s = x_r - y_sh_s;
      y_nx_s = y_r + x_sh_s;
      z_nx_s = z_r - atan_s;
    end else begin
      x_nx_s = x_r + y_sh_s;
      y_nx_s = y_r - x_sh_s;
      z_nx_s = z_r + atan_s;
    end
    if (neg_r) begin
      x_fin_s = -x_nx_s;
      y_fin_s = -y_nx_s;
    end else begin
      x_fin_s = x_nx_s;
      y_fin_s = y_nx_s;
    end
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      x_r     <= 20'sd0;
      y_r     <= 20'sd0;
      z_r     <= 20'sd0;
      cnt_r   <= 4'd0;
      neg_r   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cos_out <= 18'd0;
      sin_out <= 18'd0;
    end else begin
      state_r <= state_s;
      done    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            x_r   <= K_INIT;
            y_r   <= 20'sd0;
            z_r   <= z0_s;
            neg_r <= neg0_s;
            cnt_r <= 4'd0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        ROTATE: begin
          x_r <= x_nx_s;
          y_r <= y_nx_s;
          z_r <= z_nx_s;
          if (last_s) begin
            cnt_r   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b1;
            cos_out <= sat18(x_fin_s);
            sin_out <= sat18(y_fin_s);
          end else begin
            cnt_r   <= cnt_r + 4'd1;
            busy    <= 1'b1;
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
